fp_mult_exc_pipe: RTL and testbench

Parametrised, pipelined exception and status stage for the floating-point multiplier. Takes operands, the rounded/normalised product and its overflow/underflow/inexact indications. Produces the IEEE-style final result and per-result flags through a stallable valid/ready pipeline of configurable depth. Also keeps sticky flag accumulation and a saturating exception counter for software readback.

---
 rtl/fp_mult_exc_pipe.sv | 200 ++++++++++++++++++++
 tb/tb_fp_mult_exc_pipe.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mult_exc_pipe.sv
// Exception/status stage for the FP multiplier: special-case resolution, a stallable
// register pipeline, sticky flag accumulation and a saturating exception counter.

package rnd_enum;
  typedef enum logic [2:0] {
    IEEE_near = 3'd0,
    IEEE_zero = 3'd1,
    IEEE_pinf = 3'd2,
    IEEE_ninf = 3'd3,
    near_up   = 3'd4,
    away_zero = 3'd5
  } rnd_t;
endpackage

module fp_mult_exc_pipe
  import rnd_enum::*;
#(
  parameter int unsigned EXP_W  = 8,
  parameter int unsigned MAN_W  = 23,
  parameter int unsigned STAGES = 2,
  parameter int unsigned CNT_W  = 16,
  localparam int unsigned W     = 1 + EXP_W + MAN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic [W-1:0]     z_calc,
  input  logic             overflow,
  input  logic             underflow,
  input  logic             inexact,
  input  rnd_t             rnd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     z,
  output logic             zero_f,
  output logic             inf_f,
  output logic             nan_f,
  output logic             tiny_f,
  output logic             huge_f,
  output logic             inexact_f,
  output logic [5:0]       sticky,
  input  logic             clr_sticky,
  output logic [CNT_W-1:0] exc_count
);

  localparam int unsigned DW    = W + 6;
  localparam int unsigned FZero = 5;
  localparam int unsigned FInf  = 4;
  localparam int unsigned FNan  = 3;
  localparam int unsigned FTiny = 2;
  localparam int unsigned FHuge = 1;
  localparam int unsigned FInex = 0;

  typedef enum logic [1:0] {ClsZero, ClsInf, ClsNorm} cls_e;

  // Denormals flush to zero; an all-ones exponent is infinity regardless of mantissa.
  function automatic cls_e classify(input logic [EXP_W-1:0] e);
    if (e == '0) return ClsZero;
    if (e == '1) return ClsInf;
    return ClsNorm;
  endfunction

  cls_e             cls_a, cls_b;
  logic             s;
  logic             ovf_inf, unf_min;
  logic [EXP_W-1:0] zexp;
  logic [W-1:0]     zero_c, inf_c, max_c, min_c, nan_c;
  logic [W-1:0]     res_z;
  logic [5:0]       res_f;

  logic unused_frac;
  assign unused_frac = ^{a[MAN_W-1:0], b[MAN_W-1:0]};

  always_comb begin
    cls_a  = classify(a[W-2 -: EXP_W]);
    cls_b  = classify(b[W-2 -: EXP_W]);
    s      = a[W-1] ^ b[W-1];
    zexp   = z_calc[W-2 -: EXP_W];
    zero_c = '0;
    zero_c[W-1] = s;
    inf_c  = zero_c;
    inf_c[W-2 -: EXP_W] = '1;
    max_c  = {s, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
    min_c  = zero_c;
    min_c[MAN_W] = 1'b1;
    nan_c  = '0;
    nan_c[W-2 -: EXP_W] = '1;
    nan_c[MAN_W-1] = 1'b1;

    // Directed modes push the magnitude outward only when rounding towards the sign.
    ovf_inf = 1'b1;
    unf_min = 1'b0;
    case (rnd)
      IEEE_zero: ovf_inf = 1'b0;
      IEEE_pinf: begin
        ovf_inf = ~s;
        unf_min = ~s;
      end
      IEEE_ninf: begin
        ovf_inf = s;
        unf_min = s;
      end
      away_zero: unf_min = 1'b1;
      default: ;
    endcase

    res_z = z_calc;
    res_f = '0;
    if ((cls_a == ClsZero && cls_b == ClsInf) || (cls_a == ClsInf && cls_b == ClsZero)) begin
      res_z       = nan_c;
      res_f[FNan] = 1'b1;
    end else if (cls_a == ClsZero || cls_b == ClsZero) begin
      res_z        = zero_c;
      res_f[FZero] = 1'b1;
    end else if (cls_a == ClsInf || cls_b == ClsInf) begin
      res_z       = inf_c;
      res_f[FInf] = 1'b1;
    end else if (overflow) begin
      res_z        = ovf_inf ? inf_c : max_c;
      res_f[FInf]  = ovf_inf;
      res_f[FHuge] = 1'b1;
      res_f[FInex] = 1'b1;
    end else if (underflow) begin
      res_z        = unf_min ? min_c : zero_c;
      res_f[FZero] = ~unf_min;
      res_f[FTiny] = 1'b1;
      res_f[FInex] = 1'b1;
    end else begin
      res_f[FZero] = (zexp == '0);
      res_f[FInf]  = (zexp == '1);
      res_f[FInex] = inexact;
    end
  end

  logic [STAGES-1:0] vld_q;
  logic [DW-1:0]     data_q [STAGES];
  logic              advance;
  logic [DW-1:0]     out_data;

  assign out_valid = vld_q[STAGES-1];
  assign advance   = ~out_valid | out_ready;
  assign in_ready  = advance;

  // Whole chain moves in lockstep; bubbles are held during a stall, never collapsed.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
    end else if (advance) begin
      vld_q[0] <= in_valid;
      for (int i = 1; i < STAGES; i++) vld_q[i] <= vld_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (advance) begin
      data_q[0] <= {res_z, res_f};
      for (int i = 1; i < STAGES; i++) data_q[i] <= data_q[i-1];
    end
  end

  assign out_data = out_valid ? data_q[STAGES-1] : '0;
  assign z        = out_data[DW-1:6];
  assign {zero_f, inf_f, nan_f, tiny_f, huge_f, inexact_f} = out_data[5:0];

  logic             xfer, qual;
  logic [5:0]       sticky_q, sticky_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign xfer = out_valid & out_ready;
  assign qual = xfer & (|out_data[FInf:FHuge]);

  always_comb begin
    sticky_d = sticky_q;
    cnt_d    = cnt_q;
    if (clr_sticky) begin
      sticky_d = xfer ? out_data[5:0] : '0;
      cnt_d    = qual ? CNT_W'(1) : '0;
    end else begin
      if (xfer) sticky_d = sticky_q | out_data[5:0];
      if (qual && cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_q <= '0;
      cnt_q    <= '0;
    end else begin
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
    end
  end

  assign sticky    = sticky_q;
  assign exc_count = cnt_q;

endmodule

// File: tb/tb_fp_mult_exc_pipe.sv
// Bench for fp_mult_exc_pipe: directed corner cases plus randomized traffic scored
// against a behavioural model of the multiplier exception rules.

module tb_fp_mult_exc_pipe;
  import rnd_enum::*;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready;
  logic        overflow, underflow, inexact, clr_sticky;
  logic [31:0] a, b, z_calc, z;
  rnd_t        rnd;
  logic        zero_f, inf_f, nan_f, tiny_f, huge_f, inexact_f;
  logic [5:0]  sticky, flags;
  logic [1:0]  exc_count;

  always #5 clk = ~clk;
  assign flags = {zero_f, inf_f, nan_f, tiny_f, huge_f, inexact_f};

  fp_mult_exc_pipe #(.EXP_W(8), .MAN_W(23), .STAGES(2), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .z_calc(z_calc), .overflow(overflow), .underflow(underflow), .inexact(inexact),
    .rnd(rnd), .out_valid(out_valid), .out_ready(out_ready), .z(z), .zero_f(zero_f),
    .inf_f(inf_f), .nan_f(nan_f), .tiny_f(tiny_f), .huge_f(huge_f), .inexact_f(inexact_f),
    .sticky(sticky), .clr_sticky(clr_sticky), .exc_count(exc_count)
  );

  typedef struct packed {logic [31:0] z; logic [5:0] f;} res_t;

  int         checks = 0;
  int         failures = 0;
  res_t       pend_q[$], exp_q[$], obs_q[$];
  logic [5:0] sticky_m;
  logic [1:0] cnt_m;

  // Reference: flags are {zero, inf, nan, tiny, huge, inexact}.
  function automatic res_t ref_mult(input logic [31:0] x, input logic [31:0] y,
                                    input logic [31:0] zc, input logic ovf, input logic unf,
                                    input logic inx, input rnd_t m);
    res_t r;
    int   ex, ey, ez;
    logic sg, big;
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    ez = int'(zc[30:23]);
    sg = x[31] ^ y[31];
    if ((ex == 0 && ey == 255) || (ex == 255 && ey == 0)) begin
      r.z = 32'h7FC00000; r.f = 6'b001000; return r;
    end
    if (ex == 0 || ey == 0) begin
      r.z = {sg, 31'd0}; r.f = 6'b100000; return r;
    end
    if (ex == 255 || ey == 255) begin
      r.z = {sg, 8'hFF, 23'd0}; r.f = 6'b010000; return r;
    end
    if (ovf) begin
      big = (m == IEEE_near) || (m == near_up) || (m == away_zero) ||
            (m == IEEE_pinf && !sg) || (m == IEEE_ninf && sg);
      r.z = big ? {sg, 8'hFF, 23'd0} : {sg, 8'hFE, 23'h7FFFFF};
      r.f = big ? 6'b010011 : 6'b000011;
      return r;
    end
    if (unf) begin
      big = (m == away_zero) || (m == IEEE_pinf && !sg) || (m == IEEE_ninf && sg);
      r.z = big ? {sg, 8'h01, 23'd0} : {sg, 31'd0};
      r.f = big ? 6'b000101 : 6'b100101;
      return r;
    end
    r.z = zc;
    r.f = {ez == 0, ez == 255, 3'b000, inx};
    return r;
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] v;
    int          k;
    v = $urandom;
    k = $urandom_range(9);
    if (k == 0) v[30:23] = 8'h00;
    else if (k == 1) v[30:23] = 8'hFF;
    else v[30:23] = 8'($urandom_range(254, 1));
    return v;
  endfunction

  // Scoreboard bookkeeping only: records accepted beats, transfers and the sticky model.
  always @(negedge clk) begin : mon
    res_t e;
    if (rst) begin
      pend_q.delete();
      sticky_m = '0;
      cnt_m    = '0;
    end else begin
      if (out_valid && out_ready) begin
        if (pend_q.size() > 0) e = pend_q.pop_front();
        else begin e.z = 'x; e.f = 'x; end
        exp_q.push_back(e);
        obs_q.push_back({z, flags});
        if (clr_sticky) begin
          sticky_m = e.f;
          cnt_m    = (|e.f[4:1]) ? 2'd1 : 2'd0;
        end else begin
          sticky_m = sticky_m | e.f;
          if ((|e.f[4:1]) && cnt_m != 2'd3) cnt_m = cnt_m + 2'd1;
        end
      end else if (clr_sticky) begin
        sticky_m = '0;
        cnt_m    = '0;
      end
      if (in_valid && in_ready)
        pend_q.push_back(ref_mult(a, b, z_calc, overflow, underflow, inexact, rnd));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] x, input logic [31:0] y, input logic [31:0] zc,
                       input logic ovf, input logic unf, input logic inx, input rnd_t m);
    in_valid = 1'b1; a = x; b = y; z_calc = zc;
    overflow = ovf; underflow = unf; inexact = inx; rnd = m;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; clr_sticky = 1'b0;
    tick(); tick();
    rst = 1'b0;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      failures++; $display("FAIL reset_handshake: got %b want 01", {out_valid, in_ready});
    end
    checks++;
    if ({z, flags} !== 38'd0) begin
      failures++; $display("FAIL reset_result: got %h want 0", {z, flags});
    end
    checks++;
    if ({sticky, exc_count} !== 8'd0) begin
      failures++; $display("FAIL reset_sticky_cnt: got %h want 0", {sticky, exc_count});
    end
  endtask

  task automatic test_sign_nan();
    drive(32'h3F800000, 32'hFF800000, 32'h0, 1'b0, 1'b0, 1'b0, IEEE_near);
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL latency_early: got out_valid=%b want 0", out_valid);
    end
    drive(32'h00000000, 32'h7F800000, 32'h0, 1'b0, 1'b0, 1'b0, IEEE_near);
    tick();
    in_valid = 1'b0;
    checks++;
    if ({out_valid, z, flags} !== {1'b1, 32'hFF800000, 6'b010000}) begin
      failures++; $display("FAIL sign_inf: got %b %h %b want 1 ff800000 010000",
                           out_valid, z, flags);
    end
    tick();
    checks++;
    if ({out_valid, z, flags} !== {1'b1, 32'h7FC00000, 6'b001000}) begin
      failures++; $display("FAIL zero_times_inf: got %b %h %b want 1 7fc00000 001000",
                           out_valid, z, flags);
    end
    tick();
    checks++;
    if ({out_valid, z, flags} !== 39'd0) begin
      failures++; $display("FAIL idle_output_zero: got %b %h %b want 0 0 0", out_valid, z, flags);
    end
  endtask

  task automatic test_round_limits();
    logic [31:0] xa[4]   = '{32'h7F000000, 32'h7F000000, 32'h80800000, 32'h80800000};
    logic [31:0] xb[4]   = '{32'h7F000000, 32'h7F000000, 32'h00800000, 32'h00800000};
    logic        ov[4]   = '{1'b1, 1'b1, 1'b0, 1'b0};
    rnd_t        md[4]   = '{IEEE_zero, IEEE_near, IEEE_ninf, IEEE_pinf};
    logic [37:0] want[4] = '{{32'h7F7FFFFF, 6'b000011}, {32'h7F800000, 6'b010011},
                             {32'h80800000, 6'b000101}, {32'h80000000, 6'b100101}};
    for (int k = 0; k < 5; k++) begin
      if (k < 4) drive(xa[k], xb[k], 32'h12345678, ov[k], !ov[k], 1'b0, md[k]);
      else in_valid = 1'b0;
      tick();
      if (k >= 1) begin
        checks++;
        if ({out_valid, z, flags} !== {1'b1, want[k-1]}) begin
          failures++; $display("FAIL round_limit[%0d]: got %b %h %b want 1 %h %b", k - 1,
                               out_valid, z, flags, want[k-1][37:6], want[k-1][5:0]);
        end
      end
    end
    tick(); tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] ba[8], bb[8], bz[8];
    logic        bo[8], bu[8], bi[8];
    rnd_t        bm[8];
    logic [38:0] held;
    int          sent;
    res_t        e;
    for (int i = 0; i < 8; i++) begin
      ba[i] = rand_op(); bb[i] = rand_op(); bz[i] = rand_op();
      bo[i] = ($urandom_range(3) == 0); bu[i] = ($urandom_range(3) == 0);
      bi[i] = 1'($urandom); bm[i] = rnd_t'($urandom_range(5));
    end
    obs_q.delete(); exp_q.delete();
    sent = 0;
    held = '0;
    for (int c = 0; c < 30; c++) begin
      out_ready = !(c >= 3 && c <= 6);
      if (sent < 8) drive(ba[sent], bb[sent], bz[sent], bo[sent], bu[sent], bi[sent], bm[sent]);
      else in_valid = 1'b0;
      #1;
      if (c == 3) held = {out_valid, z, flags};
      if (c >= 3 && c <= 6) begin
        checks++;
        if (in_ready !== 1'b0) begin
          failures++; $display("FAIL stall_in_ready[c%0d]: got %b want 0", c, in_ready);
        end
      end
      if (c >= 4 && c <= 6) begin
        checks++;
        if ({out_valid, z, flags} !== held || held[38] !== 1'b1) begin
          failures++; $display("FAIL stall_stable[c%0d]: got %h want %h (valid)", c,
                               {out_valid, z, flags}, held);
        end
      end
      if (in_valid && in_ready) sent++;
      tick();
    end
    checks++;
    if (obs_q.size() != 8) begin
      failures++; $display("FAIL b2b_count: got %0d want 8", obs_q.size());
    end
    for (int i = 0; i < 8 && i < obs_q.size(); i++) begin
      e = ref_mult(ba[i], bb[i], bz[i], bo[i], bu[i], bi[i], bm[i]);
      checks++;
      if (obs_q[i] !== e) begin
        failures++; $display("FAIL b2b_beat[%0d]: got %h %b want %h %b", i,
                             obs_q[i].z, obs_q[i].f, e.z, e.f);
      end
    end
  endtask

  task automatic test_sticky();
    out_ready = 1'b1; in_valid = 1'b0;
    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
    checks++;
    if ({sticky, exc_count} !== 8'd0) begin
      failures++; $display("FAIL sticky_clear: got %b %0d want 0 0", sticky, exc_count);
    end
    drive(32'h00000000, 32'h7F800000, 32'h0, 1'b0, 1'b0, 1'b0, IEEE_near);
    tick();
    drive(32'h3F800000, 32'h3F800000, 32'h3F800000, 1'b0, 1'b0, 1'b0, IEEE_near);
    tick();
    drive(32'h3F800000, 32'h00800000, 32'h0, 1'b0, 1'b1, 1'b0, IEEE_near);
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    checks++;
    if ({sticky, exc_count} !== {6'b101101, 2'd2}) begin
      failures++; $display("FAIL sticky_accum: got %b %0d want 101101 2", sticky, exc_count);
    end
    drive(32'h3F800000, 32'h7F800000, 32'h0, 1'b0, 1'b0, 1'b0, IEEE_near);
    tick();
    in_valid = 1'b0;
    tick();
    checks++;
    if ({out_valid, inf_f} !== 2'b11) begin
      failures++; $display("FAIL inf_arrival: got %b want 11", {out_valid, inf_f});
    end
    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
    checks++;
    if ({sticky, exc_count} !== {6'b010000, 2'd1}) begin
      failures++; $display("FAIL sticky_clr_xfer: got %b %0d want 010000 1", sticky, exc_count);
    end
    for (int i = 0; i < 5; i++) begin
      drive(32'hBF800000, 32'h7F800000, 32'h0, 1'b0, 1'b0, 1'b0, IEEE_near);
      tick();
    end
    in_valid = 1'b0;
    tick(); tick(); tick();
    checks++;
    if ({sticky, exc_count} !== {6'b010000, 2'd3}) begin
      failures++; $display("FAIL cnt_saturate: got %b %0d want 010000 3", sticky, exc_count);
    end
  endtask

  task automatic test_random();
    int guard;
    obs_q.delete(); exp_q.delete();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(9) < 7)
        drive(rand_op(), rand_op(), rand_op(), ($urandom_range(4) == 0),
              ($urandom_range(4) < 2), 1'($urandom), rnd_t'($urandom_range(5)));
      else in_valid = 1'b0;
      out_ready  = ($urandom_range(9) < 7);
      clr_sticky = ($urandom_range(19) == 0);
      tick();
      checks++;
      if ({sticky, exc_count} !== {sticky_m, cnt_m}) begin
        failures++; $display("FAIL rand_sticky[c%0d]: got %b %0d want %b %0d", c,
                             sticky, exc_count, sticky_m, cnt_m);
      end
    end
    in_valid = 1'b0; out_ready = 1'b1; clr_sticky = 1'b0;
    guard = 0;
    while (pend_q.size() > 0 && guard < 20) begin
      tick();
      guard++;
    end
    tick();
    checks++;
    if (pend_q.size() != 0) begin
      failures++; $display("FAIL rand_drain: got %0d pending want 0", pend_q.size());
    end
    checks++;
    if (obs_q.size() != exp_q.size() || obs_q.size() == 0) begin
      failures++; $display("FAIL rand_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++; $display("FAIL rand_beat[%0d]: got %h %b want %h %b", i,
                             obs_q[i].z, obs_q[i].f, exp_q[i].z, exp_q[i].f);
      end
    end
    checks++;
    if ({sticky, exc_count} !== {sticky_m, cnt_m}) begin
      failures++; $display("FAIL rand_sticky_end: got %b %0d want %b %0d",
                           sticky, exc_count, sticky_m, cnt_m);
    end
  endtask

  task automatic test_reset_inflight();
    out_ready = 1'b0;
    drive(32'h3F800000, 32'h7F800000, 32'h0, 1'b0, 1'b0, 1'b0, IEEE_near);
    tick();
    drive(32'h00000000, 32'h7F800000, 32'h0, 1'b0, 1'b0, 1'b0, IEEE_near);
    tick();
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    checks++;
    if ({out_valid, sticky, exc_count} !== 9'd0) begin
      failures++; $display("FAIL reset_inflight: got %b %b %0d want 0 0 0",
                           out_valid, sticky, exc_count);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({out_valid, z} !== 33'd0) begin
        failures++; $display("FAIL reset_stale[%0d]: got %b %h want 0 0", i, out_valid, z);
      end
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; clr_sticky = 1'b0;
    a = '0; b = '0; z_calc = '0; overflow = 1'b0; underflow = 1'b0; inexact = 1'b0;
    rnd = IEEE_near;
    test_reset();
    test_sign_nan();
    test_round_limits();
    test_back_to_back();
    test_sticky();
    test_random();
    test_reset_inflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
